// File: rtl/dmem_responder.sv
// Data-memory responder: serialised load/store port into a word-organised RAM.
// It returns a one-cycle dmem_valid strobe after a fixed latency and flags faulting accesses.
module dmem_responder #(
  parameter int WIDTH        = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rstn_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             dmem_valid,
  output logic [WIDTH-1:0] rdata_o,
  output logic             err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] result;
  logic             pend_err;

  logic [WIDTH-1:0] mem [DEPTH_WORDS];

  logic [AW-1:0]    idx;
  logic             accept;
  logic             fault;
  logic [3:0]       be;
  logic [WIDTH-1:0] wlanes;
  logic [WIDTH-1:0] rword;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] load_val;

  assign idx    = addr_i[AW+1:2];
  assign accept = (state == IDLE) && req_i;
  assign busy_o = (state != IDLE);

  // Classify the presented request as faulting: bad size, misalignment, or address beyond the RAM
  always_comb begin
    fault = 1'b0;
    case (size_i)
      2'b00:   fault = 1'b0;
      2'b01:   fault = addr_i[0];
      2'b10:   fault = (addr_i[1:0] != 2'b00);
      default: fault = 1'b1;
    endcase
    if (addr_i[WIDTH-1:AW+2] != '0) fault = 1'b1;
  end

  // Build byte enables and replicate right-aligned store data onto every lane it may target
  always_comb begin
    be     = 4'b0000;
    wlanes = wdata_i;
    case (size_i)
      2'b00: begin
        be     = 4'b0001 << addr_i[1:0];
        wlanes = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be     = addr_i[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        be     = 4'b1111;
        wlanes = wdata_i;
      end
      default: begin
        be     = 4'b0000;
        wlanes = wdata_i;
      end
    endcase
  end

  // Read the addressed word and extract/extend the requested lane for a load accepted this cycle
  always_comb begin
    rword    = mem[idx];
    shifted  = rword >> {addr_i[1:0], 3'b000};
    load_val = rword;
    case (size_i)
      2'b00: load_val = unsigned_i ? {{(WIDTH-8){1'b0}}, shifted[7:0]}
                                   : {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      2'b01: load_val = unsigned_i ? {{(WIDTH-16){1'b0}}, shifted[15:0]}
                                   : {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      default: load_val = rword;
    endcase
  end

  // Commit a non-faulting store to the RAM at its acceptance edge, lane by lane
  always_ff @(posedge clk) begin
    if (rstn_i && accept && we_i && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  // Sequence IDLE/WAIT/RESP and drive the registered response outputs
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      count      <= '0;
      result     <= '0;
      pend_err   <= 1'b0;
      dmem_valid <= 1'b0;
      rdata_o    <= '0;
      err_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dmem_valid <= 1'b0;
          err_o      <= 1'b0;
          if (req_i) begin
            result   <= (fault || we_i) ? '0 : load_val;
            pend_err <= fault;
            if (we_i || READ_LATENCY == 1) begin
              state      <= RESP;
              dmem_valid <= 1'b1;
              err_o      <= fault;
              rdata_o    <= (fault || we_i) ? '0 : load_val;
            end else begin
              state <= WAIT;
              count <= CW'(READ_LATENCY - 1);
            end
          end
        end
        WAIT: begin
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state      <= RESP;
            dmem_valid <= 1'b1;
            err_o      <= pend_err;
            rdata_o    <= result;
          end
        end
        RESP: begin
          state      <= IDLE;
          dmem_valid <= 1'b0;
          err_o      <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          dmem_valid <= 1'b0;
          err_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a table of load/store vectors on a latency-2 instance,
// plus hand-written streaming and mid-transaction reset sequences on a latency-3 instance.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        rstn, req, we, uns;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        busy, valid, err;
  logic [31:0] rdata;

  logic        rstn3, req3, we3, uns3;
  logic [31:0] addr3, wdata3;
  logic [1:0]  size3;
  logic        busy3, valid3, err3;
  logic [31:0] rdata3;

  dmem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .READ_LATENCY(2)) dut (
    .clk(clk), .rstn_i(rstn), .req_i(req), .we_i(we), .addr_i(addr), .size_i(size),
    .unsigned_i(uns), .wdata_i(wdata), .busy_o(busy), .dmem_valid(valid),
    .rdata_o(rdata), .err_o(err)
  );

  dmem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rstn_i(rstn3), .req_i(req3), .we_i(we3), .addr_i(addr3), .size_i(size3),
    .unsigned_i(uns3), .wdata_i(wdata3), .busy_o(busy3), .dmem_valid(valid3),
    .rdata_o(rdata3), .err_o(err3)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        chk_data;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    logic        chk_data;
    int          due;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  exp_t sbq3[$];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
    end
  endtask

  function automatic vec_t mk(input string name, input logic w, input logic [31:0] a,
                              input logic [1:0] s, input logic u, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee, input logic cd);
    vec_t v;
    v.name = name; v.we = w; v.addr = a; v.size = s; v.uns = u; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee; v.chk_data = cd;
    return v;
  endfunction

  // Drive one request on the latency-2 instance once it is idle and queue the expected response
  task automatic applyStimulus(input vec_t v);
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checkOutput({v.name, "_idle_timeout"}, {31'b0, busy}, 32'd0);
      return;
    end
    req = 1'b1; we = v.we; addr = v.addr; size = v.size; uns = v.uns; wdata = v.wdata;
    sbq.push_back(exp_t'{v.name, v.exp_rdata, v.exp_err, v.chk_data, cyc + (v.we ? 1 : 2)});
    @(negedge clk);
    req = 1'b0;
    checkOutput({v.name, "_busy"}, {31'b0, busy}, 32'd1);
  endtask

  // Scoreboard for the latency-2 instance: match each strobe to the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (valid === 1'b1) begin
      if (sbq.size() == 0) checkOutput("unexpected_valid", {31'b0, valid}, 32'd0);
      else begin
        e = sbq.pop_front();
        checkOutput({e.name, "_err"}, {31'b0, err}, {31'b0, e.err});
        if (e.chk_data) checkOutput({e.name, "_rdata"}, rdata, e.rdata);
        checkOutput({e.name, "_cycle"}, cyc, e.due);
      end
    end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
      checkOutput({sbq[0].name, "_missing"}, {31'b0, valid}, 32'd1);
      void'(sbq.pop_front());
    end
  end

  // Scoreboard for the latency-3 instance
  always @(negedge clk) begin
    exp_t e;
    if (valid3 === 1'b1) begin
      if (sbq3.size() == 0) checkOutput("l3_unexpected_valid", {31'b0, valid3}, 32'd0);
      else begin
        e = sbq3.pop_front();
        checkOutput({e.name, "_err"}, {31'b0, err3}, {31'b0, e.err});
        if (e.chk_data) checkOutput({e.name, "_rdata"}, rdata3, e.rdata);
        checkOutput({e.name, "_cycle"}, cyc, e.due);
      end
    end else if (sbq3.size() != 0 && cyc > sbq3[0].due) begin
      checkOutput({sbq3[0].name, "_missing"}, {31'b0, valid3}, 32'd1);
      void'(sbq3.pop_front());
    end
  end

  // Hard stop in case the stimulus itself stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d;
    int n;
    rstn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; size = '0; uns = 1'b0; wdata = '0;
    rstn3 = 1'b0; req3 = 1'b0; we3 = 1'b0; addr3 = '0; size3 = '0; uns3 = 1'b0; wdata3 = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_valid", {31'b0, valid}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst3_busy", {31'b0, busy3}, 32'd0);
    checkOutput("rst3_valid", {31'b0, valid3}, 32'd0);
    checkOutput("rst3_rdata", rdata3, 32'd0);
    checkOutput("rst3_err", {31'b0, err3}, 32'd0);
    rstn = 1'b1;
    rstn3 = 1'b1;
    @(negedge clk);

    vecs.push_back(mk("st_w10",   1, 32'h010,  2'b10, 0, 32'hDEADBEEF, 32'h0,        0, 0));
    vecs.push_back(mk("ld_w10",   0, 32'h010,  2'b10, 0, 32'h0,        32'hDEADBEEF, 0, 1));
    vecs.push_back(mk("st_w20",   1, 32'h020,  2'b10, 0, 32'h11223344, 32'h0,        0, 0));
    vecs.push_back(mk("st_b21",   1, 32'h021,  2'b00, 0, 32'hABCDEF80, 32'h0,        0, 0));
    vecs.push_back(mk("ld_sb21",  0, 32'h021,  2'b00, 0, 32'h0,        32'hFFFFFF80, 0, 1));
    vecs.push_back(mk("ld_ub21",  0, 32'h021,  2'b00, 1, 32'h0,        32'h00000080, 0, 1));
    vecs.push_back(mk("ld_w20",   0, 32'h020,  2'b10, 0, 32'h0,        32'h11228044, 0, 1));
    vecs.push_back(mk("st_w30",   1, 32'h030,  2'b10, 0, 32'h55667788, 32'h0,        0, 0));
    vecs.push_back(mk("st_h32",   1, 32'h032,  2'b01, 0, 32'h12348001, 32'h0,        0, 0));
    vecs.push_back(mk("ld_uh32",  0, 32'h032,  2'b01, 1, 32'h0,        32'h00008001, 0, 1));
    vecs.push_back(mk("ld_sh32",  0, 32'h032,  2'b01, 0, 32'h0,        32'hFFFF8001, 0, 1));
    vecs.push_back(mk("ld_w30",   0, 32'h030,  2'b10, 0, 32'h0,        32'h80017788, 0, 1));
    vecs.push_back(mk("st_w40",   1, 32'h040,  2'b10, 0, 32'hCAFEF00D, 32'h0,        0, 0));
    vecs.push_back(mk("ld_w03",   0, 32'h003,  2'b10, 0, 32'h0,        32'h0,        1, 1));
    vecs.push_back(mk("st_h41",   1, 32'h041,  2'b01, 0, 32'h00001234, 32'h0,        1, 1));
    vecs.push_back(mk("st_w42",   1, 32'h042,  2'b10, 0, 32'hFFFFFFFF, 32'h0,        1, 1));
    vecs.push_back(mk("ld_sz3",   0, 32'h040,  2'b11, 0, 32'h0,        32'h0,        1, 1));
    vecs.push_back(mk("st_sz3",   1, 32'h040,  2'b11, 0, 32'h0,        32'h0,        1, 1));
    vecs.push_back(mk("ld_w1000", 0, 32'h1000, 2'b10, 0, 32'h0,        32'h0,        1, 1));
    vecs.push_back(mk("st_w1040", 1, 32'h1040, 2'b10, 0, 32'h0,        32'h0,        1, 1));
    vecs.push_back(mk("ld_w40",   0, 32'h040,  2'b10, 0, 32'h0,        32'hCAFEF00D, 0, 1));
    vecs.push_back(mk("ld_sh42",  0, 32'h042,  2'b01, 0, 32'h0,        32'hFFFFCAFE, 0, 1));
    vecs.push_back(mk("ld_ub43",  0, 32'h043,  2'b00, 1, 32'h0,        32'h000000CA, 0, 1));
    vecs.push_back(mk("ld_sb40",  0, 32'h040,  2'b00, 0, 32'h0,        32'h0000000D, 0, 1));
    vecs.push_back(mk("ld_uw10",  0, 32'h010,  2'b10, 1, 32'h0,        32'hDEADBEEF, 0, 1));
    vecs.push_back(mk("st_b43",   1, 32'h043,  2'b00, 0, 32'h0000007F, 32'h0,        0, 0));
    vecs.push_back(mk("ld_sb43",  0, 32'h043,  2'b00, 0, 32'h0,        32'h0000007F, 0, 1));
    vecs.push_back(mk("st_wffc",  1, 32'hFFC,  2'b10, 0, 32'h13579BDF, 32'h0,        0, 0));
    vecs.push_back(mk("ld_wffc",  0, 32'hFFC,  2'b10, 0, 32'h0,        32'h13579BDF, 0, 1));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Latency-3: seed a word, then hold req high with loads and watch acceptance spacing
    d = cyc;
    req3 = 1'b1; we3 = 1'b1; addr3 = 32'h50; size3 = 2'b10; uns3 = 1'b0; wdata3 = 32'h0BADF00D;
    sbq3.push_back(exp_t'{"l3_seed_store", 32'h0, 1'b0, 1'b0, d + 1});
    @(negedge clk);
    req3 = 1'b0;
    @(negedge clk);
    d = cyc;
    req3 = 1'b1; we3 = 1'b0;
    for (int k = 0; k < 4; k++)
      sbq3.push_back(exp_t'{"l3_stream", 32'h0BADF00D, 1'b0, 1'b1, d + 3 + 4 * k});
    for (int j = 1; j <= 13; j++) begin
      @(negedge clk);
      checkOutput("l3_busy_pattern", {31'b0, busy3}, {31'b0, (j % 4) != 0});
    end
    req3 = 1'b0;
    repeat (4) @(negedge clk);

    // Latency-3: reset during WAIT drops the load without a strobe
    req3 = 1'b1; we3 = 1'b0; addr3 = 32'h50; size3 = 2'b10;
    @(negedge clk);
    req3 = 1'b0;
    checkOutput("l3_busy_before_reset", {31'b0, busy3}, 32'd1);
    rstn3 = 1'b0;
    #1;
    checkOutput("l3_reset_busy", {31'b0, busy3}, 32'd0);
    checkOutput("l3_reset_valid", {31'b0, valid3}, 32'd0);
    checkOutput("l3_reset_rdata", rdata3, 32'd0);
    checkOutput("l3_reset_err", {31'b0, err3}, 32'd0);
    @(negedge clk);
    rstn3 = 1'b1;
    repeat (5) @(negedge clk);
    d = cyc;
    req3 = 1'b1; we3 = 1'b0; addr3 = 32'h50; size3 = 2'b10;
    sbq3.push_back(exp_t'{"l3_after_reset", 32'h0BADF00D, 1'b0, 1'b1, d + 3});
    @(negedge clk);
    req3 = 1'b0;

    n = 0;
    while ((sbq.size() != 0 || sbq3.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_drained", sbq.size() + sbq3.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the rv32 core: the memory-side end of the load/store handshake whose `dmem_valid` the program counter waits on when `load && !dmem_valid`. It accepts one load or store request at a time into an on-chip word-organised RAM. It returns a single-cycle `dmem_valid` pulse after a fixed, parameterised latency. Loads are returned sign- or zero-extended by access size; misaligned or out-of-range accesses are flagged.

## Interface
- `WIDTH`, 32, data/address width (only 32 supported)
- `DEPTH_WORDS`, 1024, RAM depth in 32-bit words (power of two, ≥ 4)
- `READ_LATENCY`, 2, cycles from load acceptance to `dmem_valid` (≥ 1)
- `clk`  in  1  clock, rising edge
- `rstn_i`  in  1  reset, asynchronous, active-low
- `req_i`  in  1  request valid
- `we_i`  in  1  1 = store, 0 = load
- `addr_i`  in  WIDTH  byte address
- `size_i`  in  2  00 byte, 01 half, 10 word; 11 is illegal
- `unsigned_i`  in  1  load zero-extends when 1, sign-extends when 0
- `wdata_i`  in  WIDTH  store data, right-aligned (LSBs)
- `busy_o`  out  1  responder is not in IDLE; requests are ignored
- `dmem_valid`  out  1  one-cycle response strobe (load data / store done)
- `rdata_o`  out  WIDTH  load result, valid only with `dmem_valid`
- `err_o`  out  1  access fault, valid only with `dmem_valid`

## Operation
- States: IDLE, WAIT, RESP. `busy_o = (state != IDLE)`.
- Acceptance: at a rising edge where state = IDLE and `req_i` = 1. All request fields are captured at that edge. `req_i` in any other state is ignored and is not queued.
- Fault check happens at acceptance. The access is faulted if any of the following holds:
  - `size_i` = 11
  - half with `addr_i[0]` = 1
  - word with `addr_i[1:0]` ≠ 00
  - `addr_i[WIDTH-1 : log2(DEPTH_WORDS)+2]` ≠ 0
- Faulted access: no RAM write. Response carries `err_o` = 1 and `rdata_o` = 0. Response timing is the same as a non-faulted access of the same type.
- Store timing: the RAM is written at the acceptance edge using byte enables.
  - Byte: lane `addr_i[1:0]` ← `wdata_i[7:0]`.
  - Half: lanes {`addr_i[1]`*2+1, `addr_i[1]`*2} ← `wdata_i[15:0]`.
  - Word: all lanes.
  - FSM goes IDLE → RESP.
- Load timing: the RAM word is read and the captured lane/extension controls are applied. If `READ_LATENCY` = 1, FSM goes IDLE → RESP; otherwise IDLE → WAIT, with a counter loaded to `READ_LATENCY`−1. In WAIT the counter decrements each cycle; at 1 the FSM goes to RESP.
- Load extraction:
  - Byte = word[8*a+7 : 8*a], with a = `addr_i[1:0]`.
  - Half = word[16*h+15 : 16*h], with h = `addr_i[1]`.
  - The result is sign-extended from its MSB unless `unsigned_i` = 1.
  - For a word load, `unsigned_i` is ignored.
- RESP lasts one cycle with `dmem_valid` = 1, `rdata_o` = result and `err_o` = fault. The next state is always IDLE.
- Outside RESP: `dmem_valid` = 0, `err_o` = 0, and `rdata_o` holds its last value.
- A load at the same address as a just-completed store returns the new data; no bypass is needed because accesses are serialised.
- RAM contents are not reset and are X until written.

## Timing
- Reset: state IDLE, `busy_o` 0, `dmem_valid` 0, `rdata_o` 0, `err_o` 0, counter 0.
- Load accepted at edge E: `dmem_valid` is high in the cycle after edge E+`READ_LATENCY`−1, i.e. `READ_LATENCY` cycles after acceptance. `busy_o` is high during those cycles.
- Store accepted at edge E: `dmem_valid` is high in the cycle after E, i.e. 1-cycle latency.
- Throughput: at most one request per (latency+1) cycles. A new request can be accepted at the edge that ends RESP only if it is sampled with state = RESP → ignored. It is therefore accepted at the first edge after returning to IDLE.
- Reset asserted mid-transaction: the transaction is dropped and no `dmem_valid` is produced. A store already accepted has already written RAM.
- All outputs are registered except `busy_o`, which is decoded from the state register.

## Test plan
- Store word 0xDEADBEEF at 0x10, then load word at 0x10 → first `dmem_valid` 1 cycle after store acceptance; second `dmem_valid` 2 cycles after load acceptance with `rdata_o` = 0xDEADBEEF and `err_o` = 0.
- Store byte 0x80 at 0x21, load signed byte at 0x21 → `rdata_o` = 0xFFFFFF80. Load unsigned byte at 0x21 → 0x00000080. Load word at 0x20 → bits [15:8] = 0x80, other lanes unchanged.
- Store half 0x8001 at 0x32, load unsigned half at 0x32 → 0x00008001. Load signed half → 0xFFFF8001.
- Load word at 0x03, store half at 0x41, `size_i` = 11, and load word at 0x1000 (with `DEPTH_WORDS` = 1024) → each produces `dmem_valid` with `err_o` = 1 and `rdata_o` = 0. A subsequent word read of 0x40 shows the RAM was not modified.
- With `READ_LATENCY` = 3, hold `req_i` high continuously with loads → acceptance happens every 4 cycles, `dmem_valid` occurs exactly 3 cycles after each acceptance, and requests during `busy_o` are never answered.
- Accept a load with `READ_LATENCY` = 3 and pulse `rstn_i` low during WAIT → all outputs are 0 immediately, no `dmem_valid` follows, and the next request behaves normally.
